death_sprite_fetch: RTL and testbench
=====================================

Name: death_sprite_fetch

Overview:
- Upstream stage of the 16-entry death-sprite palette lookup.
- Maps the beam position (DrawX/DrawY) onto a multi-frame death-animation sprite ROM and sequences the frames on vsync.
- Registers the 4-bit palette index plus an opaque flag; the palette stage converts these to RGB and the colour mapper uses them.
- Palette index 0 (magenta F0F) is the transparency key.

Parameters:
- SPR_W, 64, sprite width in pixels (power of 2).
- SPR_H, 64, sprite height in pixels.
- NUM_FRAMES, 4, number of animation frames stored back-to-back in the ROM.
- FRAME_HOLD, 8, vsync ticks each frame is displayed (≥1).

Ports:
- Clk  in  1  system clock
- Reset_n  in  1  asynchronous active-low reset
- DrawX  in  10  current beam column
- DrawY  in  10  current beam row
- vsync_tick  in  1  one-cycle pulse at frame start
- sprite_x  in  10  sprite top-left column
- sprite_y  in  10  sprite top-left row
- mirror  in  1  1 = character faces left (horizontal flip)
- trigger_death  in  1  pulse: start the animation
- clear  in  1  pulse: return to idle (round reset)
- rom_addr  out  ADDR_W  sprite ROM address; ADDR_W = $clog2(NUM_FRAMES*SPR_W*SPR_H)
- rom_data  in  4  ROM output; synchronous read, 1-cycle latency
- pix_index  out  4  palette index to the palette stage
- pix_opaque  out  1  draw this pixel
- anim_busy  out  1  state is PLAY
- anim_done  out  1  one-cycle pulse when the last frame is reached

Behaviour:
- Reset (async, Reset_n=0): state IDLE, frame=0, hold_cnt=0, mirror_q=0, rom_addr=0, pix_index=0, pix_opaque=0, anim_busy=0, anim_done=0, all pipeline valid bits 0.
- FSM states: IDLE, PLAY, HOLD_LAST.
- IDLE:
  - On trigger_death: go to PLAY, frame=0, hold_cnt=0, latch mirror into mirror_q.
  - The mirror input is ignored after this point.
- PLAY:
  - On vsync_tick: if hold_cnt < FRAME_HOLD-1, increment hold_cnt.
  - Otherwise hold_cnt=0, and if frame < NUM_FRAMES-1, increment frame.
  - Otherwise go to HOLD_LAST and pulse anim_done for exactly 1 cycle.
  - frame changes only on vsync_tick (no mid-frame tearing).
- HOLD_LAST: last frame shown indefinitely.
- clear in any state: go to IDLE, frame=0, hold_cnt=0. clear beats a simultaneous trigger_death.
- trigger_death in PLAY or HOLD_LAST is ignored.
- Address generation (stage 1, registered):
  - rel_x = DrawX - sprite_x and rel_y = DrawY - sprite_y, as 11-bit signed.
  - in_box = rel_x, rel_y ≥ 0, rel_x < SPR_W and rel_y < SPR_H. Negative values give out-of-box, which covers a sprite partially off-screen left or top.
  - col = mirror_q ? SPR_W-1-rel_x : rel_x.
  - rom_addr = frame*SPR_W*SPR_H + rel_y*SPR_W + col.
  - If out of box, rom_addr is held at 0.
- Stage 2: ROM read; in_box and state qualifier delayed 1 cycle to align with rom_data.
- Stage 3 (registered outputs):
  - pix_index = rom_data.
  - pix_opaque = in_box_d2 && (state_d2 != IDLE) && (rom_data != 0).
- Latency: pix_index and pix_opaque correspond to the DrawX/DrawY presented 3 Clk cycles earlier, with a fixed fully pipelined throughput of 1 pixel/cycle.
- Reset mid-pipeline: all stages cleared together, so no stale opaque pixel is emitted.

Optional Feature:
- Macro DEATH_SPRITE_BLINK_EN.
- When defined: in HOLD_LAST a 4-bit vsync counter runs, and pix_opaque is forced to 0 while counter bit 3 = 1 (blink period 16 frames, 50% duty). The counter is reset on entry to HOLD_LAST.
- When undefined: no counter is built and the last frame is shown solid.

Decomposition:
- Package death_anim_pkg:
  - state enum (IDLE, PLAY, HOLD_LAST).
  - TRANSPARENT_IDX = 4'h0.
  - BLINK_BIT = 3.
- Sub-module death_anim_seq: FSM, hold_cnt, frame, mirror_q, anim_done, blink counter.
- The top module holds the address arithmetic and the 3-stage pipeline.

Test Plan:
- Reset then idle:
  - Stimulus: sprite at (100,200), DrawX/DrawY sweeping (100..163, 200..263) with a ROM model returning non-zero.
  - Required: pix_opaque stays 0 and anim_busy=0.
- Trigger and sequence (FRAME_HOLD=8, NUM_FRAMES=4):
  - Stimulus: trigger_death, then 32 vsync_ticks.
  - Required: frame advances on ticks 8, 16 and 24. anim_done pulses once on tick 32 and HOLD_LAST is entered. anim_busy=1 from the cycle after trigger until tick 32.
- Addressing and latency:
  - Stimulus: frame=2, sprite (100,200), pixel (105,210), mirror_q=0.
  - Required: rom_addr = 2*4096 + 10*64 + 5 = 8837. pix_index equals the ROM word 3 cycles after that pixel was presented.
  - Repeat with mirror_q=1. Required: col = 58, rom_addr = 8890.
- Transparency and edges:
  - Stimulus (transparent key): rom_data=0.
  - Required: pix_opaque=0.
  - Stimulus (box edges): DrawX=99 and DrawX=164, with a non-zero ROM word.
  - Required: pix_opaque=0 at both edges.
  - Stimulus (off-screen left): sprite_x=0 with DrawX=0.
  - Required: in box.
- Simultaneous and mid-op events:
  - Stimulus: clear together with trigger_death in IDLE.
  - Required: stays IDLE.
  - Stimulus: trigger_death during PLAY.
  - Required: frame/hold_cnt unchanged.
  - Stimulus: Reset_n low mid-sweep.
  - Required: pix_opaque=0 immediately and for 3 cycles after release.
- Blink (DEATH_SPRITE_BLINK_EN defined):
  - Stimulus: enter HOLD_LAST.
  - Required: pix_opaque is visible for vsync ticks 0–7, masked for 8–15, then repeats.

Source files
------------

// File: rtl/death_anim_pkg.sv
// Shared types and constants for the death-sprite animation path.
package death_anim_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PLAY      = 2'd1,
        HOLD_LAST = 2'd2
    } anim_state_t;

    localparam logic [3:0] TRANSPARENT_IDX = 4'h0;
    localparam int         BLINK_BIT       = 3;

endpackage

// File: rtl/death_anim_seq.sv
// Death-animation sequencer: frame stepping on vsync, mirror latch and done pulse.
// Optional blinking of the held last frame when DEATH_SPRITE_BLINK_EN is defined.
module death_anim_seq
    import death_anim_pkg::*;
#(
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 8,
    parameter int FRAME_W    = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               vsync_tick,
    input  logic               mirror,
    input  logic               trigger_death,
    input  logic               clear,
    output anim_state_t        state,
    output logic [FRAME_W-1:0] frame,
    output logic               mirror_q,
    output logic               anim_done,
    output logic               blink_mask
);

    localparam int HOLD_W = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;

    anim_state_t        state_next;
    logic [FRAME_W-1:0] frame_next;
    logic [HOLD_W-1:0]  hold_cnt, hold_next;
    logic               mirror_next;
    logic               done_next;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            frame     <= '0;
            hold_cnt  <= '0;
            mirror_q  <= 1'b0;
            anim_done <= 1'b0;
        end else begin
            state     <= state_next;
            frame     <= frame_next;
            hold_cnt  <= hold_next;
            mirror_q  <= mirror_next;
            anim_done <= done_next;
        end
    end

    // clear has priority over everything, including a coincident trigger
    always_comb begin
        state_next  = state;
        frame_next  = frame;
        hold_next   = hold_cnt;
        mirror_next = mirror_q;
        done_next   = 1'b0;
        if (clear) begin
            state_next = IDLE;
            frame_next = '0;
            hold_next  = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (trigger_death) begin
                        state_next  = PLAY;
                        frame_next  = '0;
                        hold_next   = '0;
                        mirror_next = mirror;
                    end
                end
                PLAY: begin
                    if (vsync_tick) begin
                        if (hold_cnt < HOLD_W'(FRAME_HOLD - 1)) begin
                            hold_next = hold_cnt + 1'b1;
                        end else begin
                            hold_next = '0;
                            if (frame < FRAME_W'(NUM_FRAMES - 1)) begin
                                frame_next = frame + 1'b1;
                            end else begin
                                state_next = HOLD_LAST;
                                done_next  = 1'b1;
                            end
                        end
                    end
                end
                HOLD_LAST: begin
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

`ifdef DEATH_SPRITE_BLINK_EN
    logic [3:0] blink_cnt;

    // Held at zero outside HOLD_LAST, so it starts from zero on every entry
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blink_cnt <= '0;
        end else if (state != HOLD_LAST) begin
            blink_cnt <= '0;
        end else if (vsync_tick) begin
            blink_cnt <= blink_cnt + 1'b1;
        end
    end

    assign blink_mask = (state == HOLD_LAST) && blink_cnt[BLINK_BIT];
`else
    assign blink_mask = 1'b0;
`endif

endmodule

// File: rtl/death_sprite_fetch.sv
// Beam-to-sprite-ROM address generation and 3-stage pixel pipeline for the death animation.
// Build option: DEATH_SPRITE_BLINK_EN blinks the final held frame.
module death_sprite_fetch
    import death_anim_pkg::*;
#(
    parameter int SPR_W      = 64,
    parameter int SPR_H      = 64,
    parameter int NUM_FRAMES = 4,
    parameter int FRAME_HOLD = 8,
    parameter int ADDR_W     = $clog2(NUM_FRAMES * SPR_W * SPR_H)
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [9:0]        DrawX,
    input  logic [9:0]        DrawY,
    input  logic              vsync_tick,
    input  logic [9:0]        sprite_x,
    input  logic [9:0]        sprite_y,
    input  logic              mirror,
    input  logic              trigger_death,
    input  logic              clear,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [3:0]        rom_data,
    output logic [3:0]        pix_index,
    output logic              pix_opaque,
    output logic              anim_busy,
    output logic              anim_done
);

    localparam int FRAME_W = (NUM_FRAMES > 1) ? $clog2(NUM_FRAMES) : 1;
    localparam int COL_W   = $clog2(SPR_W);

    anim_state_t        state;
    logic [FRAME_W-1:0] frame;
    logic               mirror_q;
    logic               blink_mask;

    death_anim_seq #(
        .NUM_FRAMES (NUM_FRAMES),
        .FRAME_HOLD (FRAME_HOLD),
        .FRAME_W    (FRAME_W)
    ) u_seq (
        .clk           (Clk),
        .reset_n       (Reset_n),
        .vsync_tick    (vsync_tick),
        .mirror        (mirror),
        .trigger_death (trigger_death),
        .clear         (clear),
        .state         (state),
        .frame         (frame),
        .mirror_q      (mirror_q),
        .anim_done     (anim_done),
        .blink_mask    (blink_mask)
    );

    assign anim_busy = (state == PLAY);

    logic signed [10:0] rel_x, rel_y;
    logic               in_box;
    logic [COL_W-1:0]   col;
    logic [ADDR_W-1:0]  addr_calc;

    // A negative offset (sprite hanging off the left/top edge) is simply out of box
    always_comb begin
        rel_x  = {1'b0, DrawX} - {1'b0, sprite_x};
        rel_y  = {1'b0, DrawY} - {1'b0, sprite_y};
        in_box = !rel_x[10] && !rel_y[10]
                 && ({1'b0, rel_x[9:0]} < 11'(SPR_W))
                 && ({1'b0, rel_y[9:0]} < 11'(SPR_H));
        col    = mirror_q ? (COL_W'(SPR_W - 1) - rel_x[COL_W-1:0]) : rel_x[COL_W-1:0];
        addr_calc = ADDR_W'(frame) * ADDR_W'(SPR_W * SPR_H)
                  + ADDR_W'(rel_y[9:0]) * ADDR_W'(SPR_W)
                  + ADDR_W'(col);
    end

    logic in_box_d1, show_d1;
    logic in_box_d2, show_d2;

    // show_* carries the state qualifier (and blink mask) alongside each pixel
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            rom_addr   <= '0;
            in_box_d1  <= 1'b0;
            show_d1    <= 1'b0;
            in_box_d2  <= 1'b0;
            show_d2    <= 1'b0;
            pix_index  <= '0;
            pix_opaque <= 1'b0;
        end else begin
            rom_addr   <= in_box ? addr_calc : '0;
            in_box_d1  <= in_box;
            show_d1    <= (state != IDLE) && !blink_mask;
            in_box_d2  <= in_box_d1;
            show_d2    <= show_d1;
            pix_index  <= rom_data;
            pix_opaque <= in_box_d2 && show_d2 && (rom_data != TRANSPARENT_IDX);
        end
    end

endmodule

// File: tb/tb_death_sprite_fetch.sv
// Self-checking bench for death_sprite_fetch: vector tables, scoreboard and sequence checks.
// Blink expectations follow DEATH_SPRITE_BLINK_EN when it is defined.
module tb_death_sprite_fetch;

    localparam int ADDR_W = 14;

    logic              Clk = 1'b0;
    logic              Reset_n;
    logic [9:0]        DrawX, DrawY, sprite_x, sprite_y;
    logic              vsync_tick, mirror, trigger_death, clear;
    logic [ADDR_W-1:0] rom_addr;
    logic [3:0]        rom_data = 4'h0;
    logic [3:0]        pix_index;
    logic              pix_opaque, anim_busy, anim_done;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    typedef struct {
        int due;
        int addr;
        int idx;
        bit opq;
    } sb_t;

    typedef struct {
        int dx;
        int dy;
        int sx;
        int sy;
        bit in_box;
        int addr;
    } vec_t;

    sb_t addr_q[$];
    sb_t pix_q[$];

    death_sprite_fetch dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .DrawX         (DrawX),
        .DrawY         (DrawY),
        .vsync_tick    (vsync_tick),
        .sprite_x      (sprite_x),
        .sprite_y      (sprite_y),
        .mirror        (mirror),
        .trigger_death (trigger_death),
        .clear         (clear),
        .rom_addr      (rom_addr),
        .rom_data      (rom_data),
        .pix_index     (pix_index),
        .pix_opaque    (pix_opaque),
        .anim_busy     (anim_busy),
        .anim_done     (anim_done)
    );

    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc++;

    // ROM model: zero (transparent) at column 7 of every row, otherwise a non-zero hash
    function automatic logic [3:0] rom_word(input int a);
        logic [13:0] v;
        logic [3:0]  h;
        v = a[13:0];
        h = v[3:0] ^ v[7:4] ^ v[11:8] ^ {2'b00, v[13:12]};
        if (v[5:0] == 6'd7) return 4'h0;
        if (h == 4'h0) return 4'hF;
        return h;
    endfunction

    always @(posedge Clk) rom_data <= rom_word(int'(rom_addr));

    task automatic checkOutput(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge Clk) begin
        sb_t e;
        if (addr_q.size() > 0 && addr_q[0].due == cyc) begin
            e = addr_q.pop_front();
            checkOutput("rom_addr", int'(rom_addr), e.addr);
        end
        if (pix_q.size() > 0 && pix_q[0].due == cyc) begin
            e = pix_q.pop_front();
            checkOutput("pix_index", int'(pix_index), e.idx);
            checkOutput("pix_opaque", int'(pix_opaque), int'(e.opq));
        end
    end

    task automatic applyStimulus(input int dx, input int dy, input int sx, input int sy,
                                 input bit in_box, input int addr, input bit vis);
        sb_t  e;
        logic [3:0] w;
        DrawX    = 10'(dx);
        DrawY    = 10'(dy);
        sprite_x = 10'(sx);
        sprite_y = 10'(sy);
        e.due  = cyc + 1;
        e.addr = in_box ? addr : 0;
        w      = rom_word(e.addr);
        e.idx  = int'(w);
        e.opq  = in_box && vis && (w != 4'h0);
        addr_q.push_back(e);
        e.due  = cyc + 3;
        pix_q.push_back(e);
        @(negedge Clk);
    endtask

    task automatic waitCycles(input int n);
        for (int i = 0; i < n; i++) @(negedge Clk);
    endtask

    task automatic park();
        DrawX = 10'd100; DrawY = 10'd200; sprite_x = 10'd100; sprite_y = 10'd200;
        waitCycles(4);
    endtask

    task automatic pulse(input bit trig, input bit clr);
        trigger_death = trig;
        clear         = clr;
        @(negedge Clk);
        trigger_death = 1'b0;
        clear         = 1'b0;
    endtask

    task automatic pulseVsync();
        vsync_tick = 1'b1;
        @(negedge Clk);
        vsync_tick = 1'b0;
    endtask

    task automatic doTick(input int exp_addr, input bit exp_busy, input bit exp_done);
        vsync_tick = 1'b1;
        @(negedge Clk);
        vsync_tick = 1'b0;
        checkOutput("anim_done", int'(anim_done), int'(exp_done));
        @(negedge Clk);
        checkOutput("anim_done_width", int'(anim_done), 0);
        checkOutput("frame_addr", int'(rom_addr), exp_addr);
        checkOutput("anim_busy", int'(anim_busy), int'(exp_busy));
    endtask

    vec_t vec_a[13];
    vec_t vec_m[6];

    initial begin
        bit vis;

        // frame 2, mirror_q = 0
        vec_a[0]  = '{105, 210, 100, 200, 1'b1, 8837};
        vec_a[1]  = '{100, 200, 100, 200, 1'b1, 8192};
        vec_a[2]  = '{163, 263, 100, 200, 1'b1, 12287};
        vec_a[3]  = '{ 99, 210, 100, 200, 1'b0, 0};
        vec_a[4]  = '{164, 210, 100, 200, 1'b0, 0};
        vec_a[5]  = '{110, 199, 100, 200, 1'b0, 0};
        vec_a[6]  = '{110, 264, 100, 200, 1'b0, 0};
        vec_a[7]  = '{107, 205, 100, 200, 1'b1, 8519};
        vec_a[8]  = '{  0,   0,   0,   0, 1'b1, 8192};
        vec_a[9]  = '{ 63,   5,   0,   0, 1'b1, 8575};
        vec_a[10] = '{1020,  3, 990,   0, 1'b1, 8414};
        vec_a[11] = '{  5,   3, 1000,  0, 1'b0, 0};
        vec_a[12] = '{499, 400, 500, 400, 1'b0, 0};
        // frame 2, mirror_q = 1
        vec_m[0]  = '{105, 210, 100, 200, 1'b1, 8890};
        vec_m[1]  = '{100, 200, 100, 200, 1'b1, 8255};
        vec_m[2]  = '{163, 200, 100, 200, 1'b1, 8192};
        vec_m[3]  = '{164, 200, 100, 200, 1'b0, 0};
        vec_m[4]  = '{  0,   0,   0,   0, 1'b1, 8255};
        vec_m[5]  = '{156, 205, 100, 200, 1'b1, 8519};

        Reset_n = 1'b0;
        DrawX = '0; DrawY = '0; sprite_x = '0; sprite_y = '0;
        vsync_tick = 1'b0; mirror = 1'b0; trigger_death = 1'b0; clear = 1'b0;
        waitCycles(3);
        checkOutput("reset_pix_opaque", int'(pix_opaque), 0);
        checkOutput("reset_pix_index", int'(pix_index), 0);
        checkOutput("reset_rom_addr", int'(rom_addr), 0);
        checkOutput("reset_anim_busy", int'(anim_busy), 0);
        checkOutput("reset_anim_done", int'(anim_done), 0);
        Reset_n = 1'b1;
        @(negedge Clk);

        $display("[TB] idle sweep");
        for (int i = 0; i < 64; i++) applyStimulus(100 + i, 200 + i, 100, 200, 1'b1, i * 65, 1'b0);
        waitCycles(4);
        checkOutput("idle_anim_busy", int'(anim_busy), 0);

        $display("[TB] trigger and sequence, mirror 0");
        park();
        mirror = 1'b0;
        pulse(1'b1, 1'b0);
        checkOutput("busy_after_trigger", int'(anim_busy), 1);
        for (int k = 1; k <= 16; k++) doTick((k / 8) * 4096, 1'b1, 1'b0);

        for (int i = 0; i < 13; i++)
            applyStimulus(vec_a[i].dx, vec_a[i].dy, vec_a[i].sx, vec_a[i].sy,
                          vec_a[i].in_box, vec_a[i].addr, 1'b1);
        waitCycles(4);

        park();
        pulse(1'b1, 1'b0);
        checkOutput("trigger_in_play_addr", int'(rom_addr), 8192);
        checkOutput("trigger_in_play_busy", int'(anim_busy), 1);
        for (int k = 17; k <= 32; k++)
            doTick(((k < 32) ? (k / 8) : 3) * 4096, k < 32, k == 32);

        $display("[TB] hold last frame");
        for (int t = 0; t < 20; t++) begin
`ifdef DEATH_SPRITE_BLINK_EN
            vis = (t % 16) < 8;
`else
            vis = 1'b1;
`endif
            applyStimulus(105, 210, 100, 200, 1'b1, 12933, vis);
            pulseVsync();
        end
        waitCycles(4);
        checkOutput("hold_last_busy", int'(anim_busy), 0);

        $display("[TB] clear, then clear with trigger");
        pulse(1'b0, 1'b1);
        checkOutput("clear_busy", int'(anim_busy), 0);
        applyStimulus(105, 210, 100, 200, 1'b1, 645, 1'b0);
        pulse(1'b1, 1'b1);
        checkOutput("clear_beats_trigger", int'(anim_busy), 0);
        applyStimulus(105, 210, 100, 200, 1'b1, 645, 1'b0);
        waitCycles(4);

        $display("[TB] trigger and sequence, mirror 1");
        park();
        mirror = 1'b1;
        pulse(1'b1, 1'b0);
        mirror = 1'b0;
        for (int k = 1; k <= 16; k++) doTick((k / 8) * 4096 + 63, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++)
            applyStimulus(vec_m[i].dx, vec_m[i].dy, vec_m[i].sx, vec_m[i].sy,
                          vec_m[i].in_box, vec_m[i].addr, 1'b1);

        $display("[TB] reset mid-sweep");
        for (int i = 0; i < 3; i++) applyStimulus(101 + i, 201, 100, 200, 1'b1, 8192 + 64 + 62 - i, 1'b1);
        #2;
        Reset_n = 1'b0;
        addr_q.delete();
        pix_q.delete();
        #1;
        checkOutput("midreset_pix_opaque", int'(pix_opaque), 0);
        checkOutput("midreset_rom_addr", int'(rom_addr), 0);
        checkOutput("midreset_anim_busy", int'(anim_busy), 0);
        waitCycles(2);
        Reset_n = 1'b1;
        DrawX = 10'd105; DrawY = 10'd210;
        for (int i = 0; i < 3; i++) begin
            @(negedge Clk);
            checkOutput("post_reset_pix_opaque", int'(pix_opaque), 0);
        end

        waitCycles(4);
        checkOutput("scoreboard_drain", addr_q.size() + pix_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
